// File: rtl/evt_aer_pkg.sv
// Shared definitions for the AER event packetizer: word-width derivation,
// event type codes and the arbitration FSM state encoding.
package evt_aer_pkg;

  localparam logic [1:0] EVT_PIX     = 2'b01;
  localparam logic [1:0] EVT_PIX_REL = 2'b11;
  localparam logic [1:0] EVT_TH      = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HOLD      = 2'd1,
    ST_MARK      = 2'd2,
    ST_MARK_HOLD = 2'd3
  } evt_state_e;

  function automatic int evt_width(input int grp_add, input int lvl0_add, input int ts_w);
    return 2 + ts_w + 2 * (grp_add + lvl0_add) + 1;
  endfunction

endpackage

// File: rtl/evt_sync_fifo.sv
// First-word-fall-through synchronous FIFO; extra pointer MSB separates full
// from empty. Head data reads as zero while empty.
module evt_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 21
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push    = i_wr_en & ~o_full;
  assign w_pop     = i_rd_en & ~o_empty;
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage is not reset; the empty-gated read keeps stale words invisible.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/evt_aer_packetizer.sv
// Timestamps granted pixel events, formats AER words, inserts time-high markers
// on timestamp wrap and buffers everything in a FWFT FIFO toward readout.
module evt_aer_packetizer
  import evt_aer_pkg::*;
#(
  parameter int Lvl0_ADD = 2,
  parameter int GRP_ADD  = 2,
  parameter int TS_W     = 10,
  parameter int EPOCH_W  = 8,
  parameter int DEPTH    = 8,
  localparam int EVT_W   = evt_width(GRP_ADD, Lvl0_ADD, TS_W)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                evt_valid_i,
  input  logic [GRP_ADD-1:0]  grp_x_i,
  input  logic [GRP_ADD-1:0]  grp_y_i,
  input  logic [Lvl0_ADD-1:0] x_add_i,
  input  logic [Lvl0_ADD-1:0] y_add_i,
  input  logic                polarity_i,
  input  logic                grp_release_i,
  output logic                stall_o,
  output logic [EVT_W-1:0]    evt_data_o,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic                fifo_full_o,
  output logic [7:0]          drop_cnt_o
);

  localparam int EXT_W = EVT_W - 2;
  localparam logic [TS_W-1:0]    TS_MAX    = '1;
  localparam logic [TS_W-1:0]    TS_ONE    = TS_W'(1);
  localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);

  logic [TS_W-1:0]    r_ts;
  logic [EPOCH_W-1:0] r_epoch;
  evt_state_e         r_state;
  logic               r_stall;
  logic [EVT_W-1:0]   r_hold_word;
  logic [7:0]         r_drop_cnt;

  logic               w_wrap, w_hold_v, w_mark_req, w_in_ok, w_full, w_empty;
  logic               w_wr_en, w_mark_nxt, w_hold_nxt, w_capture, w_drop_hold, w_drop_in;
  logic [EPOCH_W-1:0] w_epoch_nxt;
  logic [EVT_W-1:0]   w_pix_word, w_mark_word, w_wr_data;
  logic [1:0]         w_drop_n;
  logic [8:0]         w_drop_sum;
  evt_state_e         w_state_nxt;

  assign w_wrap      = (r_ts == TS_MAX);
  assign w_epoch_nxt = w_wrap ? (r_epoch + EPOCH_ONE) : r_epoch;
  assign w_pix_word  = {(grp_release_i ? EVT_PIX_REL : EVT_PIX), r_ts,
                        grp_x_i, x_add_i, grp_y_i, y_add_i, polarity_i};
  assign w_mark_word = {EVT_TH, EXT_W'(w_epoch_nxt)};
  assign w_hold_v    = (r_state == ST_HOLD) || (r_state == ST_MARK_HOLD);
  assign w_mark_req  = (r_state == ST_MARK) || (r_state == ST_MARK_HOLD) || w_wrap;
  assign w_in_ok     = evt_valid_i & ~r_stall;
  assign w_drop_n    = {1'b0, w_drop_hold} + {1'b0, w_drop_in};
  assign w_drop_sum  = {1'b0, r_drop_cnt} + {7'b0, w_drop_n};

  // Single write port: marker beats held pixel beats incoming pixel.
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_data   = '0;
    w_mark_nxt  = 1'b0;
    w_hold_nxt  = w_hold_v;
    w_capture   = 1'b0;
    w_drop_hold = 1'b0;
    w_drop_in   = evt_valid_i & r_stall;
    if (w_mark_req) begin
      if (!w_full) begin
        w_wr_en   = 1'b1;
        w_wr_data = w_mark_word;
      end else begin
        w_mark_nxt = 1'b1;
      end
      if (w_in_ok) begin
        w_capture  = 1'b1;
        w_hold_nxt = 1'b1;
      end else begin
        w_hold_nxt = w_hold_v;
      end
    end else if (w_hold_v) begin
      w_hold_nxt = 1'b0;
      if (!w_full) begin
        w_wr_en   = 1'b1;
        w_wr_data = r_hold_word;
      end else begin
        w_drop_hold = 1'b1;
      end
    end else if (w_in_ok) begin
      if (!w_full) begin
        w_wr_en   = 1'b1;
        w_wr_data = w_pix_word;
      end else begin
        w_drop_in = 1'b1;
      end
    end else begin
      w_wr_en = 1'b0;
    end
    case ({w_mark_nxt, w_hold_nxt})
      2'b00:   w_state_nxt = ST_RUN;
      2'b01:   w_state_nxt = ST_HOLD;
      2'b10:   w_state_nxt = ST_MARK;
      2'b11:   w_state_nxt = ST_MARK_HOLD;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ST_RUN;
      r_stall     <= 1'b0;
      r_hold_word <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stall <= w_mark_nxt | w_hold_nxt;
      if (w_capture) r_hold_word <= w_pix_word;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ts       <= '0;
      r_epoch    <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_ts       <= r_ts + TS_ONE;
      r_epoch    <= w_epoch_nxt;
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  evt_sync_fifo #(.DEPTH(DEPTH), .WIDTH(EVT_W)) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_data),
    .i_rd_en   (evt_ready_i),
    .o_rd_data (evt_data_o),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  assign stall_o     = r_stall;
  assign evt_valid_o = ~w_empty;
  assign fifo_full_o = w_full;
  assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_evt_aer_packetizer.sv
// Scoreboard bench for evt_aer_packetizer: expected words queued at stimulus
// time, compared in order as the consumer pops them.
module tb_evt_aer_packetizer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        evt_valid_i;
  logic [1:0]  grp_x_i, grp_y_i, x_add_i, y_add_i;
  logic        polarity_i, grp_release_i;
  logic        stall_o;
  logic [20:0] evt_data_o;
  logic        evt_valid_o;
  logic        evt_ready_i;
  logic        fifo_full_o;
  logic [7:0]  drop_cnt_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [20:0] sb[$];
  logic [20:0] m_exp;
  logic [9:0]  m_ts;

  evt_aer_packetizer dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .evt_valid_i   (evt_valid_i),
    .grp_x_i       (grp_x_i),
    .grp_y_i       (grp_y_i),
    .x_add_i       (x_add_i),
    .y_add_i       (y_add_i),
    .polarity_i    (polarity_i),
    .grp_release_i (grp_release_i),
    .stall_o       (stall_o),
    .evt_data_o    (evt_data_o),
    .evt_valid_o   (evt_valid_o),
    .evt_ready_i   (evt_ready_i),
    .fifo_full_o   (fifo_full_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference free-running timestamp: value of ts during the current cycle.
  always @(posedge clk or posedge reset_i) begin
    if (reset_i) m_ts <= 10'd0;
    else         m_ts <= m_ts + 10'd1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] pix(input logic rel, input logic [9:0] ts,
                                      input logic [1:0] gx, input logic [1:0] gy,
                                      input logic [1:0] xa, input logic [1:0] ya,
                                      input logic pol);
    return {(rel ? 2'b11 : 2'b01), ts, gx, xa, gy, ya, pol};
  endfunction

  function automatic logic [20:0] mark(input logic [7:0] epoch);
    return {2'b10, 11'd0, epoch};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rel, input logic [1:0] gx, input logic [1:0] gy,
                       input logic [1:0] xa, input logic [1:0] ya, input logic pol);
    evt_valid_i   = 1'b1;
    grp_release_i = rel;
    grp_x_i       = gx;
    grp_y_i       = gy;
    x_add_i       = xa;
    y_add_i       = ya;
    polarity_i    = pol;
  endtask

  task automatic idle();
    evt_valid_i   = 1'b0;
    grp_release_i = 1'b0;
    grp_x_i       = 2'd0;
    grp_y_i       = 2'd0;
    x_add_i       = 2'd0;
    y_add_i       = 2'd0;
    polarity_i    = 1'b0;
  endtask

  task automatic wait_ts(input logic [9:0] t);
    for (int i = 0; i < 2000; i++) begin
      if (m_ts == t) break;
      tick();
    end
    chk("wait_ts", {22'd0, m_ts}, {22'd0, t});
  endtask

  task automatic drain();
    evt_ready_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && !evt_valid_o) break;
      tick();
    end
    chk("drain_done", sb.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
    chk({tag, "_valid"}, {31'd0, evt_valid_o}, 32'd0);
    chk({tag, "_data"},  {11'd0, evt_data_o}, 32'd0);
    chk({tag, "_full"},  {31'd0, fifo_full_o}, 32'd0);
    chk({tag, "_drop"},  {24'd0, drop_cnt_o}, 32'd0);
  endtask

  // Consumer side: every accepted head word must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset_i && evt_valid_o && evt_ready_i) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
      end else begin
        m_exp = sb.pop_front();
        chk("out_word", {11'd0, evt_data_o}, {11'd0, m_exp});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_i     = 1'b1;
    evt_ready_i = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    reset_i = 1'b0;

    // Single event at ts=5 appears one cycle later
    wait_ts(10'd5);
    drive(1'b0, 2'd1, 2'd2, 2'd3, 2'd0, 1'b1);
    sb.push_back(21'b01_0000000101_0111_1000_1);
    tick();
    idle();
    chk("t1_valid", {31'd0, evt_valid_o}, 32'd1);
    chk("t1_data", {11'd0, evt_data_o}, {11'd0, 21'b01_0000000101_0111_1000_1});
    chk("t1_stall", {31'd0, stall_o}, 32'd0);
    tick();

    // Ten events into a stalled consumer: 8 stored, 2 dropped, no stall
    evt_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      logic [1:0] a, b, c, d;
      a = 2'(i); b = 2'(i + 1); c = 2'(i * 3); d = 2'(i >> 1);
      if (i < 8) sb.push_back(pix(a[0], m_ts, a, b, c, d, a[1]));
      drive(a[0], a, b, c, d, a[1]);
      tick();
      chk("t2_stall", {31'd0, stall_o}, 32'd0);
    end
    idle();
    chk("t2_full", {31'd0, fifo_full_o}, 32'd1);
    chk("t2_drop", {24'd0, drop_cnt_o}, 32'd2);
    drain();

    // Event in the wrap cycle: marker first, held pixel keeps ts=1023
    wait_ts(10'd1023);
    drive(1'b1, 2'd3, 2'd1, 2'd2, 2'd2, 1'b0);
    sb.push_back(mark(8'd1));
    sb.push_back(pix(1'b1, 10'd1023, 2'd3, 2'd1, 2'd2, 2'd2, 1'b0));
    chk("t3_stall_w", {31'd0, stall_o}, 32'd0);
    tick();
    idle();
    chk("t3_stall_w1", {31'd0, stall_o}, 32'd1);
    tick();
    chk("t3_stall_w2", {31'd0, stall_o}, 32'd0);
    drain();

    // Wrap with a full FIFO: marker waits, stall held, nothing dropped
    evt_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] a;
      a = 2'(3 - i);
      sb.push_back(pix(1'b0, m_ts, a, 2'(i), a, 2'(i + 2), a[0]));
      drive(1'b0, a, 2'(i), a, 2'(i + 2), a[0]);
      tick();
    end
    idle();
    chk("t4_full", {31'd0, fifo_full_o}, 32'd1);
    wait_ts(10'd1023);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_stall", {31'd0, stall_o}, 32'd1);
    end
    sb.push_back(mark(8'd2));
    drain();
    chk("t4_drop", {24'd0, drop_cnt_o}, 32'd2);
    chk("t4_stall_end", {31'd0, stall_o}, 32'd0);

    // Reset mid-burst with entries queued and a held event
    evt_ready_i = 1'b0;
    wait_ts(10'd1020);
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 2'(j), 2'd1, 2'd2, 2'(j), 1'b1);
      tick();
    end
    drive(1'b0, 2'd2, 2'd2, 2'd1, 2'd1, 1'b0);
    tick();
    idle();
    chk("t5_hold_stall", {31'd0, stall_o}, 32'd1);
    chk("t5_valid", {31'd0, evt_valid_o}, 32'd1);
    reset_i = 1'b1;
    #1;
    chk_zero_outputs("t5_reset");
    sb.delete();
    tick();
    tick();
    reset_i = 1'b0;
    wait_ts(10'd3);
    drive(1'b0, 2'd2, 2'd3, 2'd1, 2'd2, 1'b1);
    sb.push_back(pix(1'b0, 10'd3, 2'd2, 2'd3, 2'd1, 2'd2, 1'b1));
    tick();
    idle();
    chk("t5_post_valid", {31'd0, evt_valid_o}, 32'd1);
    chk("t5_post_data", {11'd0, evt_data_o}, {11'd0, 21'b01_0000000011_1001_1110_1});
    drain();

    // 300 drops saturate the drop counter at 255
    evt_ready_i = 1'b0;
    for (int i = 0; i < 308; i++) begin
      if (i < 8) sb.push_back(pix(1'b0, m_ts, 2'd1, 2'd1, 2'(i), 2'(i), 1'b0));
      drive(1'b0, 2'd1, 2'd1, 2'(i), 2'(i), 1'b0);
      tick();
      if (i == 261) chk("t6_drop_254", {24'd0, drop_cnt_o}, 32'd254);
      if (i == 262) chk("t6_drop_255", {24'd0, drop_cnt_o}, 32'd255);
    end
    idle();
    chk("t6_drop_sat", {24'd0, drop_cnt_o}, 32'd255);
    drain();

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/evt_aer_packetizer.md
Name: evt_aer_packetizer

Overview:
- Sits directly downstream of the level-0 group-select stage in the pixel-hierarchy arbiter.
- Takes the single granted pixel per cycle (group coordinates, in-group x/y address, polarity, group-release flag), timestamps it and formats it into an AER event word.
- Buffers event words in a FWFT FIFO toward the readout interface (valid/ready), inserts time-high markers on timestamp wrap, and back-pressures the arbiter with a stall.

Parameters:
- Lvl0_ADD, 2, in-group pixel address width (x and y each)
- GRP_ADD, 2, group coordinate width (x and y each)
- TS_W, 10, low timestamp counter width
- EPOCH_W, 8, time-high epoch counter width; must be ≤ EVT_W-2
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- EVT_W, 2+TS_W+2*(GRP_ADD+Lvl0_ADD)+1 = 21, event word width (derived, not overridable)

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- evt_valid_i  in  1  granted pixel event present this cycle
- grp_x_i  in  GRP_ADD  column index of the active group
- grp_y_i  in  GRP_ADD  row index of the active group
- x_add_i  in  Lvl0_ADD  in-group x address
- y_add_i  in  Lvl0_ADD  in-group y address
- polarity_i  in  1  event polarity (1=ON)
- grp_release_i  in  1  last event of the active group
- stall_o  out  1  upstream must not present new events
- evt_data_o  out  EVT_W  head-of-FIFO event word
- evt_valid_o  out  1  FIFO non-empty
- evt_ready_i  in  1  consumer accepts head word
- fifo_full_o  out  1  FIFO holds DEPTH entries
- drop_cnt_o  out  8  saturating count of dropped pixel events

Behaviour:
- Reset (async assert, sync deassert): all outputs 0, FIFO empty, ts=0, epoch=0, hold and marker flags clear, drop_cnt=0. Any in-flight held event or pending marker is discarded.
- ts counter increments every cycle. On wrap from 2^TS_W-1 to 0, epoch increments (wrapping) and marker_pending is set in that same cycle.
- Pixel word: [EVT_W-1:EVT_W-2] = 2'b01, or 2'b11 when grp_release_i=1.
  - Then ts (value in the cycle evt_valid_i is sampled).
  - Then x = {grp_x_i, x_add_i}, y = {grp_y_i, y_add_i}, polarity in bit 0.
- Marker word: type 2'b10, new epoch zero-extended in the low bits.
- Single FIFO write port. Per-cycle write priority:
  1. Pending marker.
  2. Held pixel event.
  3. Incoming evt_valid_i event.
- An incoming event that loses arbitration goes into the 1-entry hold register (keeping its original ts) if the hold is empty. Otherwise it is dropped.
- A write is permitted only if the FIFO was not full at the start of the cycle. A same-cycle pop does not free space for the write.
- Full FIFO handling:
  - Incoming or held pixel event: dropped, drop_cnt_o += 1, saturating at 255.
  - Marker: never dropped; stays pending until written.
- stall_o = marker_pending | hold_valid (registered flags). An event presented while stall_o=1 is dropped and counted.
- FSM states:
  - RUN: no hold, no marker.
  - HOLD: hold_valid.
  - MARK: marker_pending, hold empty.
  - MARK_HOLD: both set.
- Transitions follow the priority above, e.g. MARK_HOLD → HOLD after the marker write → RUN after the held write.
- A wrap occurring while already in MARK/MARK_HOLD sets no second flag. The marker writes the current epoch; only the latest epoch is emitted.
- Output: FWFT. evt_data_o = mem[rd_ptr] when non-empty, else 0.
  - Pop on evt_valid_o & evt_ready_i.
  - Pointers are log2(DEPTH)+1 bits; full/empty come from MSB compare.
- Latency: event sampled in cycle N appears on evt_valid_o in cycle N+1 (empty FIFO, no conflict).
- Simultaneous push+pop on a non-full, non-empty FIFO: occupancy unchanged.

Decomposition:
- Package evt_aer_pkg: EVT_W derivation function, type codes (EVT_PIX=2'b01, EVT_PIX_REL=2'b11, EVT_TH=2'b10), FSM state enum.
- Sub-module evt_sync_fifo (parameters DEPTH, WIDTH): FWFT storage, pointers, full/empty flags.

Test Plan:
- Single event, grp=(1,2), x_add=3, y_add=0, pol=1 at ts=5 → next cycle evt_data_o = 21'b01_0000000101_0111_1000_1, evt_valid_o=1.
- Hold evt_ready_i=0, present 10 events on consecutive non-stalled cycles → first 8 enqueued, fifo_full_o=1, drop_cnt_o=2, stall_o stays 0.
- Event presented in the wrap cycle (ts=1023→0) → marker (type 10, epoch=1) written first, stall_o=1 for 1 cycle, pixel word with ts=1023 written next.
- Wrap with FIFO full and ready=0 for 5 cycles → marker pending, stall_o=1 throughout; after one pop the marker is enqueued; drop_cnt_o unchanged.
- Assert reset_i mid-burst with 4 entries queued and hold valid → all outputs 0 immediately; after release first event has ts counted from 0.
- Drive 300 drops → drop_cnt_o saturates at 255.
